// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Definitions shared by the fetch stage and inst_decoder:
//   - PCSource encodings that decode/execute drive on the redirect bus
//   - fetch FSM state type
//   - helper that decides whether a redirect is actually taken
package fetch_unit_pkg;

    // PCSource encodings
    localparam logic [2:0] PCSRC_SEQ    = 3'd0;  // sequential, never redirects
    localparam logic [2:0] PCSRC_JUMP   = 3'd1;  // J / JAL, absolute jumpAddr
    localparam logic [2:0] PCSRC_JREG   = 3'd2;  // JR / JALR, register target
    localparam logic [2:0] PCSRC_BRANCH = 3'd3;  // conditional branch, PC-relative

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // one cycle after reset before the first request
        ST_REQ  = 2'd1,  // request presented, waiting for imem_ready
        ST_WAIT = 2'd2,  // request accepted, waiting for imem_rvalid
        ST_HOLD = 2'd3   // instruction presented, waiting for inst_ready
    } fetch_state_t;

    // A redirect is taken for jumps, register jumps and taken branches only.
    function automatic logic redirect_taken(
        input logic       valid,
        input logic [2:0] src,
        input logic       taken
    );
        return valid & ((src == PCSRC_JUMP) |
                        (src == PCSRC_JREG) |
                        ((src == PCSRC_BRANCH) & taken));
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pc             in   current fetch PC (word-aligned)
//     redirect_valid in   control-flow resolution present this cycle
//     redirect_PC    in   PC of the resolving instruction
//     PCSource       in   target kind (see fetch_unit_pkg)
//     branch_taken   in   branch condition (PCSource == branch only)
//     branchAddr     in   sign-extended, pre-shifted branch offset
//     jumpAddr       in   absolute jump target
//     targetReg      in   register jump target
//     redirect_take  out  redirect must be applied this cycle
//     next_PC        out  redirect target when redirect_take, else pc+4
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 32
) (
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_PC,
    input  logic [2:0]              PCSource,
    input  logic                    branch_taken,
    input  logic [ADDRESS_BITS-1:0] branchAddr,
    input  logic [ADDRESS_BITS-1:0] jumpAddr,
    input  logic [ADDRESS_BITS-1:0] targetReg,
    output logic                    redirect_take,
    output logic [ADDRESS_BITS-1:0] next_PC
);

    localparam logic [ADDRESS_BITS-1:0] WORD_STEP = ADDRESS_BITS'(4);

    logic [ADDRESS_BITS-1:0] seq_pc;
    logic [ADDRESS_BITS-1:0] target;

    // All additions wrap modulo 2^ADDRESS_BITS.
    assign seq_pc        = pc + WORD_STEP;
    assign redirect_take = redirect_taken(redirect_valid, PCSource, branch_taken);

    always_comb begin
        target = seq_pc;
        case (PCSource)
            PCSRC_SEQ:    target = seq_pc;
            PCSRC_JUMP:   target = jumpAddr;
            PCSRC_JREG:   target = targetReg;
            PCSRC_BRANCH: target = redirect_PC + WORD_STEP + branchAddr;
            default:      target = seq_pc;
        endcase

        next_PC = redirect_take ? target : seq_pc;
        // Forcing the low bits clears targetReg[1:0] for JR/JALR and keeps
        // every fetch address word-aligned.
        next_PC[1:0] = 2'b00;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Owns the PC, issues one word read at a time to
//   instruction memory and presents {instruction, inst_PC} to decode.
//   Redirects from decode/execute override everything; a read already
//   accepted by memory when a redirect lands is squashed on return.
//   Ports:
//     clock, reset            rising-edge clock, synchronous active-high reset
//     imem_req/imem_addr      read request and word address (held until ready)
//     imem_ready              memory accepts the request this cycle
//     imem_rvalid/imem_rdata  in-order read return
//     inst_valid/instruction/inst_PC  instruction to decode
//     inst_ready              decode consumes this cycle
//     redirect_valid, redirect_PC, PCSource, branch_taken,
//     branchAddr, jumpAddr, targetReg  control-flow redirect bus
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned                 ADDRESS_BITS = 32,
    parameter int unsigned                 DATA_WIDTH   = 32,
    parameter logic [ADDRESS_BITS-1:0]     RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,

    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_rvalid,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,

    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,

    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_PC,
    input  logic [2:0]              PCSource,
    input  logic                    branch_taken,
    input  logic [ADDRESS_BITS-1:0] branchAddr,
    input  logic [ADDRESS_BITS-1:0] jumpAddr,
    input  logic [ADDRESS_BITS-1:0] targetReg
);

    fetch_state_t            state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [ADDRESS_BITS-1:0] req_pc;   // address of the outstanding read
    logic                    squash;   // outstanding read is stale, drop its data
    logic                    redirect_take;
    logic [ADDRESS_BITS-1:0] next_PC;

    fetch_next_pc #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_next_pc (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_PC    (redirect_PC),
        .PCSource       (PCSource),
        .branch_taken   (branch_taken),
        .branchAddr     (branchAddr),
        .jumpAddr       (jumpAddr),
        .targetReg      (targetReg),
        .redirect_take  (redirect_take),
        .next_PC        (next_PC)
    );

    // Request is a pure decode of the state register; the address is the PC
    // register itself, so both are stable for the whole REQ period.
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            req_pc      <= '0;
            squash      <= 1'b0;
            inst_valid  <= 1'b0;
            instruction <= '0;
            inst_PC     <= '0;
        end else if (redirect_take) begin
            // Redirect wins over every other event, including a same-cycle
            // consume of a held instruction.
            pc         <= next_PC;
            inst_valid <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        // The outstanding read returns on this very edge and
                        // is dropped here, so nothing is left to squash.
                        squash <= 1'b0;
                        state  <= ST_REQ;
                    end else begin
                        squash <= 1'b1;
                        state  <= ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        // Memory took the old address on this edge.
                        squash <= 1'b1;
                        state  <= ST_WAIT;
                    end else begin
                        state  <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (imem_ready) begin
                        req_pc <= pc;
                        pc     <= next_PC;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= ST_REQ;
                        end else begin
                            instruction <= imem_rdata;
                            inst_PC     <= req_pc;
                            inst_valid  <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } inst_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_PC;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic [2:0]  pc_source;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic [31:0] target_reg;

    // second instance with a wrapping reset PC
    logic        reset_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ready_w;
    logic        imem_rvalid_w;
    logic [31:0] imem_rdata_w;
    logic        inst_valid_w;
    logic        inst_ready_w;
    logic [31:0] instruction_w;
    logic [31:0] inst_PC_w;
    logic        redirect_valid_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    inst_t       exp_inst[$];

    int grant_cnt = 0;   // requests the memory model will still accept
    int mem_lat   = 1;   // cycles from accept edge to rvalid edge

    assign imem_ready = (grant_cnt != 0);

    fetch_unit #(
        .ADDRESS_BITS (32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_PC        (inst_PC),
        .redirect_valid (redirect_valid),
        .redirect_PC    (redirect_PC),
        .PCSource       (pc_source),
        .branch_taken   (branch_taken),
        .branchAddr     (branch_addr),
        .jumpAddr       (jump_addr),
        .targetReg      (target_reg)
    );

    fetch_unit #(
        .ADDRESS_BITS (32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'hFFFF_FFFC)
    ) dut_w (
        .clock          (clock),
        .reset          (reset_w),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_ready     (imem_ready_w),
        .imem_rvalid    (imem_rvalid_w),
        .imem_rdata     (imem_rdata_w),
        .inst_valid     (inst_valid_w),
        .inst_ready     (inst_ready_w),
        .instruction    (instruction_w),
        .inst_PC        (inst_PC_w),
        .redirect_valid (redirect_valid_w),
        .redirect_PC    (redirect_PC),
        .PCSource       (pc_source),
        .branch_taken   (branch_taken),
        .branchAddr     (branch_addr),
        .jumpAddr       (jump_addr),
        .targetReg      (target_reg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: accept observed at negedge, response driven 1ns after posedge.
    initial begin : mem_model
        bit          acc;
        logic [31:0] acc_addr;
        logic [31:0] mem_addr;
        int          mem_cnt;
        bit          mem_pend;
        mem_pend    = 1'b0;
        mem_cnt     = 0;
        mem_addr    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clock);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            @(posedge clock);
            #1;
            imem_rvalid = 1'b0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ~mem_addr;
                    mem_pend    = 1'b0;
                end
            end
            if (acc) begin
                if (grant_cnt > 0) grant_cnt--;
                mem_addr = acc_addr;
                mem_pend = 1'b1;
                mem_cnt  = mem_lat - 1;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ~mem_addr;
                    mem_pend    = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: compares accepted requests and consumed instructions.
    always @(negedge clock) begin : monitor
        logic [31:0] ea;
        inst_t       ei;
        if (!reset) begin
            if (imem_req && imem_ready) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr: got request %h, none expected", imem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (imem_addr !== ea) begin
                        errors++;
                        $display("FAIL req_addr: got %h want %h", imem_addr, ea);
                    end
                end
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (exp_inst.size() == 0) begin
                    errors++;
                    $display("FAIL inst_out: got %h@%h, none expected", instruction, inst_PC);
                end else begin
                    ei = exp_inst.pop_front();
                    if (instruction !== ei.data || inst_PC !== ei.pc) begin
                        errors++;
                        $display("FAIL inst_out: got %h@%h want %h@%h",
                                 instruction, inst_PC, ei.data, ei.pc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        inst_t e;
        exp_addr.push_back(a);
        if (delivered) begin
            e.data = ~a;
            e.pc   = a;
            exp_inst.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_inst.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: timeout with %0d requests and %0d instructions outstanding",
                     name, exp_addr.size(), exp_inst.size());
            exp_addr.delete();
            exp_inst.delete();
        end
    endtask

    // which: 0 = request accepted, 1 = imem_req high, 2 = inst_valid high
    task automatic wait_for(input string name, input int which);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clock);
            case (which)
                0:       hit = imem_req && imem_ready;
                1:       hit = imem_req;
                default: hit = inst_valid;
            endcase
            n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: event %0d not seen within 200 cycles", name, which);
        end
        tick();
    endtask

    task automatic pulse_redirect(input logic [2:0] src, input logic taken,
                                  input logic [31:0] rpc, input logic [31:0] baddr,
                                  input logic [31:0] jaddr, input logic [31:0] treg,
                                  input logic valid);
        pc_source      = src;
        branch_taken   = taken;
        redirect_PC    = rpc;
        branch_addr    = baddr;
        jump_addr      = jaddr;
        target_reg     = treg;
        redirect_valid = valid;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        reset_w          = 1'b1;
        inst_ready       = 1'b1;
        redirect_valid   = 1'b0;
        redirect_PC      = '0;
        pc_source        = 3'd0;
        branch_taken     = 1'b0;
        branch_addr      = '0;
        jump_addr        = '0;
        target_reg       = '0;
        imem_ready_w     = 1'b0;
        imem_rvalid_w    = 1'b0;
        imem_rdata_w     = '0;
        inst_ready_w     = 1'b1;
        redirect_valid_w = 1'b0;

        tick();
        tick();
        @(negedge clock);
        check("rst_imem_req",    {31'b0, imem_req},   32'd0);
        check("rst_inst_valid",  {31'b0, inst_valid}, 32'd0);
        check("rst_instruction", instruction,          32'd0);
        check("rst_inst_PC",     inst_PC,              32'd0);
        check("rst_imem_addr",   imem_addr,            32'd0);

        // 1: back-to-back sequential fetch
        tick();
        expect_fetch(32'h0, 1);
        expect_fetch(32'h4, 1);
        expect_fetch(32'h8, 1);
        expect_fetch(32'hC, 1);
        grant_cnt = 4;
        reset     = 1'b0;
        wait_idle("seq_fetch");

        // 2: decode stalls, output must hold and no request issued
        inst_ready = 1'b0;
        expect_fetch(32'h10, 1);
        grant_cnt = 1;
        wait_for("hold_valid", 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_instruction", instruction, 32'hFFFF_FFEF);
            check("hold_inst_PC", inst_PC, 32'h10);
            check("hold_no_req", {31'b0, imem_req}, 32'd0);
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
        end
        tick();
        inst_ready = 1'b1;
        wait_idle("hold_release");

        // 3: taken branch while waiting for read data
        mem_lat = 3;
        expect_fetch(32'h14, 0);
        grant_cnt = 1;
        wait_for("branch_accept", 0);
        pulse_redirect(3'd3, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1);
        mem_lat = 1;
        expect_fetch(32'hC, 1);
        grant_cnt = 1;
        wait_idle("branch_in_wait");

        // 4: jump in the same cycle memory accepts the old address
        wait_for("jump_req", 1);
        expect_fetch(32'h10, 0);
        expect_fetch(32'h400, 1);
        grant_cnt = 2;
        pulse_redirect(3'd1, 1'b0, 32'h0, 32'h0, 32'h400, 32'h0, 1'b1);
        wait_idle("jump_with_accept");

        // 5a: register jump, low bits cleared
        pulse_redirect(3'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1003, 1'b1);
        expect_fetch(32'h1000, 1);
        grant_cnt = 1;
        wait_idle("jreg");

        // 5b: not-taken branch, sequential source, and inactive bus are ignored
        pulse_redirect(3'd3, 1'b0, 32'h1000, 32'h100, 32'h0, 32'h0, 1'b1);
        pulse_redirect(3'd0, 1'b1, 32'h1000, 32'h100, 32'h2000, 32'h3000, 1'b1);
        pulse_redirect(3'd1, 1'b0, 32'h0, 32'h0, 32'h5000, 32'h0, 1'b0);
        expect_fetch(32'h1004, 1);
        expect_fetch(32'h1008, 1);
        grant_cnt = 2;
        wait_idle("no_redirect");

        // 6a: PC wrap through a jump to the last word
        pulse_redirect(3'd1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        expect_fetch(32'hFFFF_FFFC, 1);
        expect_fetch(32'h0, 1);
        grant_cnt = 2;
        wait_idle("pc_wrap");

        // 6b: reset during WAIT, late rvalid must be ignored
        mem_lat = 3;
        expect_fetch(32'h4, 0);
        grant_cnt = 1;
        wait_for("rst_wait_accept", 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_mid_req",   {31'b0, imem_req},   32'd0);
        tick();
        @(negedge clock);
        check("rst_mid_req2",  {31'b0, imem_req},   32'd1);
        check("rst_mid_addr",  imem_addr,           32'h0);
        tick();
        tick();
        @(negedge clock);
        check("rst_late_rvalid_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        mem_lat = 1;
        expect_fetch(32'h0, 1);
        grant_cnt = 1;
        wait_idle("after_mid_reset");

        // wrapping reset PC on the second instance
        imem_ready_w = 1'b1;
        reset_w      = 1'b0;
        tick();
        @(negedge clock);
        check("w_first_req",  {31'b0, imem_req_w}, 32'd1);
        check("w_first_addr", imem_addr_w, 32'hFFFF_FFFC);
        tick();
        imem_rvalid_w = 1'b1;
        imem_rdata_w  = 32'h1234_5678;
        tick();
        imem_rvalid_w = 1'b0;
        @(negedge clock);
        check("w_inst_valid", {31'b0, inst_valid_w}, 32'd1);
        check("w_instruction", instruction_w, 32'h1234_5678);
        check("w_inst_PC", inst_PC_w, 32'hFFFF_FFFC);
        tick();
        @(negedge clock);
        check("w_second_req",  {31'b0, imem_req_w}, 32'd1);
        check("w_second_addr", imem_addr_w, 32'h0);
        tick();
        reset_w = 1'b1;
        tick();
        reset_w = 1'b0;
        @(negedge clock);
        check("w_rst_req",   {31'b0, imem_req_w},   32'd0);
        check("w_rst_valid", {31'b0, inst_valid_w}, 32'd0);
        tick();
        @(negedge clock);
        check("w_rst_addr", imem_addr_w, 32'hFFFF_FFFC);
        imem_ready_w = 1'b0;

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
